// File: rtl/cache_pkg.sv
// Shared definitions for the cache command path: trace command codes,
// sequencer state encoding and the command-code validity check.
package cache_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [3:0] {
    READ_REQ_L1_D    = 4'd0,
    WRITE_REQ_L1_D   = 4'd1,
    READ_REQ_L1_I    = 4'd2,
    SNOOP_INVALIDATE = 4'd3,
    SNOOP_READ       = 4'd4,
    SNOOP_WRITE      = 4'd5,
    SNOOP_RWIM       = 4'd6,
    CLEAR_RESET      = 4'd8,
    PRINT_CONTENTS   = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } seq_state_e;

  // Codes 7 and 10-15 are holes in the trace encoding and are never issued.
  function automatic logic cmd_is_valid(input logic [3:0] code);
    return (code <= 4'd6) || (code == 4'd8) || (code == 4'd9);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding {command, address} trace entries.
// Head entry is presented combinationally on rdata_o.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is refused even if a pop frees a slot this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cache_cmd_sequencer.sv
// Replays buffered trace commands to the cache, one strobe per command with a
// fixed idle gap afterwards, dropping invalid codes and keeping statistics.
module cache_cmd_sequencer
  import cache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int GAP    = 100,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_n,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [3:0]        out_n,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic [15:0]       read_cntr,
  output logic [15:0]       write_cntr,
  output logic [15:0]       snoop_cntr,
  output logic [15:0]       drop_cntr
);

  localparam int EW = 4 + ADDR_W;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0]          head;
  logic [3:0]             head_n;
  logic [ADDR_W-1:0]      head_addr;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   push;
  logic                   pop;
  logic                   load;
  logic                   drop;
  logic                   decide;

  seq_state_e        state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [3:0]        out_n_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [15:0]       read_q, read_d, write_q, write_d;
  logic [15:0]       snoop_q, snoop_d, drop_q, drop_d;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_n, in_addr}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_n    = head[EW-1 -: 4];
  assign head_addr = head[ADDR_W-1:0];

  // The dispatch decision is shared by IDLE and the last GAP cycle so that
  // back-to-back commands come out exactly GAP+1 cycles apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    decide  = 1'b0;
    case (state_q)
      ST_IDLE:  decide = 1'b1;
      ST_ISSUE: begin
        gap_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == '0) decide = 1'b1;
        else             gap_d  = gap_q - 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (decide) begin
      state_d = ST_IDLE;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (cmd_is_valid(head_n)) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    read_d  = read_q;
    write_d = write_q;
    snoop_d = snoop_q;
    drop_d  = drop_q;
    if (state_q == ST_ISSUE) begin
      case (out_n_q)
        READ_REQ_L1_D, READ_REQ_L1_I: read_d  = sat_inc(read_q);
        WRITE_REQ_L1_D:               write_d = sat_inc(write_q);
        SNOOP_INVALIDATE, SNOOP_READ,
        SNOOP_WRITE, SNOOP_RWIM:      snoop_d = sat_inc(snoop_q);
        CLEAR_RESET: begin
          read_d  = '0;
          write_d = '0;
          snoop_d = '0;
        end
        default: ;
      endcase
    end
    if (drop) drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      out_n_q    <= '0;
      out_addr_q <= '0;
      read_q     <= '0;
      write_q    <= '0;
      snoop_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (load) begin
        out_n_q    <= head_n;
        out_addr_q <= head_addr;
      end
      read_q  <= read_d;
      write_q <= write_d;
      snoop_q <= snoop_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid  = (state_q == ST_ISSUE);
  assign out_n      = out_n_q;
  assign out_addr   = out_addr_q;
  assign busy       = (fifo_count != '0) || (state_q != ST_IDLE);
  assign read_cntr  = read_q;
  assign write_cntr = write_q;
  assign snoop_cntr = snoop_q;
  assign drop_cntr  = drop_q;

endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Bench for cache_cmd_sequencer: table of single commands with expected
// counters, a strobe scoreboard, and hand-written multi-cycle sequences.
module tb_cache_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int GAP    = 4;
  localparam int ADDR_W = 32;

  logic        clk;
  logic        rstb;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_n;
  logic [31:0] in_addr;
  logic        out_valid;
  logic [3:0]  out_n;
  logic [31:0] out_addr;
  logic        busy;
  logic [15:0] read_cntr, write_cntr, snoop_cntr, drop_cntr;

  int n_total = 0;
  int n_pass  = 0;
  logic [35:0] exp_q [$];

  typedef struct {
    logic [3:0]  n;
    logic [31:0] addr;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [15:0] sn;
    logic [15:0] dr;
  } vec_t;

  vec_t vecs [12];

  cache_cmd_sequencer #(
    .DEPTH  (DEPTH),
    .GAP    (GAP),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_n       (in_n),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_n      (out_n),
    .out_addr   (out_addr),
    .busy       (busy),
    .read_cntr  (read_cntr),
    .write_cntr (write_cntr),
    .snoop_cntr (snoop_cntr),
    .drop_cntr  (drop_cntr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic code_ok(input logic [3:0] c);
    return (c < 4'd7) || (c == 4'd8) || (c == 4'd9);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired, required event did not occur", name);
  endtask

  // Scoreboard: every strobe must match the oldest expected valid command.
  always @(negedge clk) begin
    logic [35:0] e;
    if (rstb && out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: got n=%0d addr=%0h, required no strobe", out_n, out_addr);
      end else begin
        e = exp_q.pop_front();
        check("issue_n", 64'(out_n), 64'(e[35:32]));
        check("issue_addr", 64'(out_addr), 64'(e[31:0]));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rstb     = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstb = 1'b1;
  endtask

  // Holds in_valid until the entry is taken; waits = cycles in_valid was high.
  task automatic push_entry(input logic [3:0] n, input logic [31:0] a, output int waits);
    logic acc;
    int t;
    in_valid = 1'b1;
    in_n     = n;
    in_addr  = a;
    t = 0;
    do begin
      acc = in_ready;
      @(negedge clk);
      t++;
    end while (!acc && t < 500);
    if (!acc) fail_now("push_accept");
    else if (code_ok(n)) exp_q.push_back({n, a});
    in_valid = 1'b0;
    waits = t;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail_now("drain");
  endtask

  initial begin
    int w;
    int gap;
    bit found;

    vecs[0]  = '{4'd0,  32'h10, 16'd1, 16'd0, 16'd0, 16'd0};
    vecs[1]  = '{4'd1,  32'h20, 16'd1, 16'd1, 16'd0, 16'd0};
    vecs[2]  = '{4'd2,  32'h30, 16'd2, 16'd1, 16'd0, 16'd0};
    vecs[3]  = '{4'd3,  32'h40, 16'd2, 16'd1, 16'd1, 16'd0};
    vecs[4]  = '{4'd6,  32'h50, 16'd2, 16'd1, 16'd2, 16'd0};
    vecs[5]  = '{4'd7,  32'h60, 16'd2, 16'd1, 16'd2, 16'd1};
    vecs[6]  = '{4'd9,  32'h70, 16'd2, 16'd1, 16'd2, 16'd1};
    vecs[7]  = '{4'd15, 32'h80, 16'd2, 16'd1, 16'd2, 16'd2};
    vecs[8]  = '{4'd5,  32'h90, 16'd2, 16'd1, 16'd3, 16'd2};
    vecs[9]  = '{4'd8,  32'hA0, 16'd0, 16'd0, 16'd0, 16'd2};
    vecs[10] = '{4'd4,  32'hB0, 16'd0, 16'd0, 16'd1, 16'd2};
    vecs[11] = '{4'd10, 32'hC0, 16'd0, 16'd0, 16'd1, 16'd3};

    rstb     = 1'b0;
    in_valid = 1'b0;
    in_n     = '0;
    in_addr  = '0;

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_n", 64'(out_n), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_counters", {read_cntr, write_cntr, snoop_cntr, drop_cntr}, 64'd0);

    // Latency and strobe spacing with two queued commands
    in_valid = 1'b1;
    in_n     = 4'd0;
    in_addr  = 32'h10;
    exp_q.push_back({4'd0, 32'h10});
    @(negedge clk);
    in_n    = 4'd1;
    in_addr = 32'h20;
    exp_q.push_back({4'd1, 32'h20});
    @(negedge clk);
    in_valid = 1'b0;
    check("first_strobe_latency", 64'(out_valid), 64'd1);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!out_valid && gap < 50);
    check("strobe_spacing", 64'(gap), 64'(GAP + 1));
    drain();
    check("pair_read_cntr", 64'(read_cntr), 64'd1);
    check("pair_write_cntr", 64'(write_cntr), 64'd1);

    // Table: one command at a time, cumulative counters after each
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push_entry(vecs[i].n, vecs[i].addr, w);
      drain();
      check($sformatf("vec%0d_read", i), 64'(read_cntr), 64'(vecs[i].rd));
      check($sformatf("vec%0d_write", i), 64'(write_cntr), 64'(vecs[i].wr));
      check($sformatf("vec%0d_snoop", i), 64'(snoop_cntr), 64'(vecs[i].sn));
      check($sformatf("vec%0d_drop", i), 64'(drop_cntr), 64'(vecs[i].dr));
    end

    // Full FIFO backpressure while the sequencer sits in its gap
    do_reset();
    push_entry(4'd0, 32'h100, w);
    gap = 0;
    while (!out_valid && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    if (!out_valid) fail_now("prime_strobe");
    for (int i = 1; i <= 4; i++) push_entry(4'(i), 32'h100 + 32'(i), w);
    check("full_in_ready_low", 64'(in_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    push_entry(4'd5, 32'h105, w);
    check("fifth_accept_wait", 64'(w), 64'd2);
    drain();
    check("full_snoop_cntr", 64'(snoop_cntr), 64'd3);

    // Invalid codes dropped
    do_reset();
    push_entry(4'd7, 32'h200, w);
    push_entry(4'd3, 32'h210, w);
    push_entry(4'd15, 32'h220, w);
    drain();
    check("drop_snoop_cntr", 64'(snoop_cntr), 64'd1);
    check("drop_drop_cntr", 64'(drop_cntr), 64'd2);
    check("drop_read_cntr", 64'(read_cntr), 64'd0);

    // Clear command zeroes statistics in the cycle after its strobe
    do_reset();
    push_entry(4'd0, 32'h400, w);
    push_entry(4'd2, 32'h410, w);
    push_entry(4'd0, 32'h420, w);
    push_entry(4'd8, 32'h430, w);
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_n == 4'd8) found = 1'b1;
    end
    if (!found) fail_now("clear_strobe");
    check("read_before_clear", 64'(read_cntr), 64'd3);
    @(negedge clk);
    check("read_after_clear", 64'(read_cntr), 64'd0);
    drain();

    // Reset during the gap with three entries still queued
    do_reset();
    push_entry(4'd0, 32'h300, w);
    push_entry(4'd1, 32'h310, w);
    push_entry(4'd2, 32'h320, w);
    push_entry(4'd4, 32'h330, w);
    check("pre_reset_read", 64'(read_cntr), 64'd1);
    rstb = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_counters", {read_cntr, write_cntr, snoop_cntr, drop_cntr}, 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("post_release_out_valid", 64'(out_valid), 64'd0);
    repeat (30) @(negedge clk);
    check("post_release_busy", 64'(busy), 64'd0);

    // Saturation of the read counter
    do_reset();
    @(negedge clk);
    force dut.read_q = 16'hFFFE;
    @(negedge clk);
    release dut.read_q;
    check("preload_read", 64'(read_cntr), 64'hFFFE);
    push_entry(4'd0, 32'h500, w);
    push_entry(4'd0, 32'h510, w);
    push_entry(4'd2, 32'h520, w);
    drain();
    check("sat_read_cntr", 64'(read_cntr), 64'hFFFF);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_cmd_sequencer.md
CACHE_CMD_SEQUENCER -- requirements
Module: cache_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter GAP, default 100, idle cycles forced after each issued command (>=1).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rstb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream trace entry present.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept entry.
REQ-008 SHALL have port in_n  input  4  trace command code.
REQ-009 SHALL have port in_addr  input  ADDR_W  trace address.
REQ-010 SHALL have port out_valid  output  1  one-cycle command strobe to cache.
REQ-011 SHALL have ports out_n (4) and out_addr (ADDR_W), outputs, command/address to cache, held after strobe.
REQ-012 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-013 SHALL have ports read_cntr, write_cntr, snoop_cntr, drop_cntr  output  16 each  statistics.

Function
REQ-014 SHALL accept an entry on a rising edge where in_valid & in_ready; in_ready = (FIFO count < DEPTH), from registered count only.
REQ-015 SHALL NOT accept a push when FIFO full, even if a pop occurs same cycle.
REQ-016 SHALL implement FSM states IDLE, ISSUE, GAP.
REQ-017 IDLE: if FIFO non-empty and head code valid, pop, load out_n/out_addr, go ISSUE; if head code invalid, pop, drop_cntr+1, stay IDLE; if empty, stay IDLE.
REQ-018 Valid codes SHALL be 0-6, 8, 9; codes 7 and 10-15 are invalid and never issued.
REQ-019 ISSUE: out_valid=1 for exactly this one cycle; load gap counter with GAP-1; go GAP.
REQ-020 GAP: out_valid=0; decrement counter; at counter 0 apply the IDLE decision of REQ-017 in the same cycle (direct GAP->ISSUE allowed).
REQ-021 Consecutive out_valid pulses SHALL be exactly GAP+1 cycles apart when FIFO stays non-empty with valid codes.
REQ-022 Latency: entry accepted at edge E into empty FIFO with FSM IDLE -> out_valid high in cycle after edge E+1.
REQ-023 On ISSUE: code 0 or 2 -> read_cntr+1; code 1 -> write_cntr+1; codes 3-6 -> snoop_cntr+1; code 9 -> no counter change.
REQ-024 On ISSUE of code 8: read_cntr, write_cntr, snoop_cntr SHALL become 0; drop_cntr unchanged.
REQ-025 All counters SHALL saturate at 16'hFFFF.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; order strictly FIFO.
REQ-027 out_n/out_addr SHALL change only on ISSUE entry.

Reset
REQ-028 rstb low SHALL immediately clear FIFO (count 0), FSM to IDLE, gap counter 0, out_valid 0, out_n 0, out_addr 0, all counters 0; in_ready=1 after reset.
REQ-029 Reset mid-GAP or mid-ISSUE SHALL discard buffered entries; no out_valid for 1 cycle after release.

Structure
REQ-030 Command codes (READ_REQ_L1_D=0 ... PRINT_CONTENTS=9) and ADDR_W default SHALL reside in shared package cache_pkg.
REQ-031 FIFO SHALL be sub-module cmd_fifo (push/pop/full/empty/count, async active-low reset).

Verification
REQ-032 Push {n=0,a=0x10} then {n=1,a=0x20}, GAP=4 -> two out_valid pulses 5 cycles apart, read_cntr=1, write_cntr=1.
REQ-033 Push 5 entries back-to-back, DEPTH=4 -> in_ready low after 4th accept, 5th accepted only after first pop; order preserved.
REQ-034 Push codes 7, 3, 15 -> only n=3 issued, snoop_cntr=1, drop_cntr=2.
REQ-035 Issue 3 reads then n=8 -> read_cntr 3 then 0 in cycle after n=8 strobe.
REQ-036 Assert rstb low during GAP with 3 entries queued -> out_valid 0, busy 0, all counters 0, in_ready 1.
REQ-037 Force read_cntr to 16'hFFFE, issue 3 reads -> read_cntr=16'hFFFF.
